// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM encoding,
// depth derivation and the write-port priority pick used by every arbiter.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int MAX_WR = 2;
    localparam int MAX_AW = 16;

    typedef struct packed {
        logic       hit;
        logic [0:0] idx;
    } wsel_t;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Later ports overwrite earlier matches, so the highest-index enabled port wins.
    function automatic wsel_t pick_wr(input logic [MAX_WR-1:0]             we,
                                      input logic [MAX_WR-1:0][MAX_AW-1:0] wa,
                                      input logic [MAX_AW-1:0]             addr);
        wsel_t res;
        res.hit = 1'b0;
        res.idx = 1'b0;
        for (int k = 0; k < MAX_WR; k++) begin
            if (we[k] && (wa[k] == addr)) begin
                res.hit = 1'b1;
                res.idx = k[0:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_wsel.sv
// Per-address write-port arbiter: reports whether any enabled write port
// targets addr and which port wins.
module regfile_wsel
    import regfile_pkg::*;
#(
    parameter int NUM_WR = 1,
    parameter int ADDR_W = 5
) (
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [0:0]               idx
);

    logic [MAX_WR-1:0]             we_s;
    logic [MAX_WR-1:0][MAX_AW-1:0] wa_s;
    wsel_t                         sel_s;

    // Unused port slots are tied off so the shared picker sees a fixed shape.
    for (genvar k = 0; k < MAX_WR; k++) begin : g_port
        if (k < NUM_WR) begin : g_used
            assign we_s[k] = we[k];
            assign wa_s[k] = MAX_AW'(wa[k*ADDR_W +: ADDR_W]);
        end else begin : g_pad
            assign we_s[k] = 1'b0;
            assign wa_s[k] = {MAX_AW{1'b0}};
        end
    end

    assign sel_s = pick_wr(we_s, wa_s, MAX_AW'(addr));
    assign hit   = sel_s.hit;
    assign idx   = sel_s.idx;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset clear sweep,
// same-cycle write bypass and registered write-conflict flag.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 1,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wa,
    input  logic [NUM_WR*DATA_W-1:0] wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic                     ready,
    output logic                     conflict
);

    localparam int DEPTH = depth_of(ADDR_W);

    state_t              state_r;
    state_t              state_nx;
    logic [ADDR_W:0]     cnt_r;
    logic [ADDR_W:0]     cnt_nx;
    logic                ready_r;
    logic                conflict_r;
    logic                conf_s;
    logic [DATA_W-1:0]   wd_s  [MAX_WR];
    logic [DATA_W-1:0]   mem_s [DEPTH];

    for (genvar k = 0; k < MAX_WR; k++) begin : g_wd
        if (k < NUM_WR) begin : g_used
            assign wd_s[k] = wd[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign wd_s[k] = {DATA_W{1'b0}};
        end
    end

    // Sweep sequencing: one entry per cycle, hand over to RUN on the last one.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        case (state_r)
            CLEAR: begin
                cnt_nx = cnt_r + {{ADDR_W{1'b0}}, 1'b1};
                if (cnt_r == (ADDR_W+1)'(DEPTH-1)) begin
                    state_nx = RUN;
                end else begin
                    state_nx = CLEAR;
                end
            end
            RUN: begin
                state_nx = RUN;
            end
            default: begin
                state_nx = CLEAR;
                cnt_nx   = {(ADDR_W+1){1'b0}};
            end
        endcase
    end

    // Control state, ready and conflict registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= CLEAR;
            cnt_r      <= {(ADDR_W+1){1'b0}};
            ready_r    <= 1'b0;
            conflict_r <= 1'b0;
        end else begin
            state_r    <= state_nx;
            cnt_r      <= cnt_nx;
            ready_r    <= (state_nx == RUN);
            conflict_r <= conf_s;
        end
    end

    if (NUM_WR == 2) begin : g_conf
        logic zero_hit_s;
        assign zero_hit_s = (ZERO_R0 != 0) && (wa[0 +: ADDR_W] == {ADDR_W{1'b0}});
        assign conf_s = (state_r == RUN) && we[0] && we[1]
                        && (wa[0 +: ADDR_W] == wa[ADDR_W +: ADDR_W]) && !zero_hit_s;
    end else begin : g_noconf
        assign conf_s = 1'b0;
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        logic              hit_s;
        logic [0:0]        idx_s;
        logic              wen_s;
        logic [DATA_W-1:0] ent_r;

        regfile_wsel #(.NUM_WR(NUM_WR), .ADDR_W(ADDR_W)) u_wsel (
            .we   (we),
            .wa   (wa),
            .addr (ADDR_W'(e)),
            .hit  (hit_s),
            .idx  (idx_s)
        );

        assign wen_s = hit_s && (state_r == RUN) && !((ZERO_R0 != 0) && (e == 0));

        // Storage entry: no reset, the sweep provides the known-zero start.
        always_ff @(posedge clk) begin
            if (state_r == CLEAR) begin
                if (cnt_r[ADDR_W-1:0] == ADDR_W'(e)) begin
                    ent_r <= {DATA_W{1'b0}};
                end
            end else if (wen_s) begin
                ent_r <= wd_s[idx_s];
            end
        end

        assign mem_s[e] = ent_r;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] a_s;
        logic              hit_s;
        logic [0:0]        idx_s;
        logic [DATA_W-1:0] d_s;

        assign a_s = ra[p*ADDR_W +: ADDR_W];

        regfile_wsel #(.NUM_WR(NUM_WR), .ADDR_W(ADDR_W)) u_wsel (
            .we   (we),
            .wa   (wa),
            .addr (a_s),
            .hit  (hit_s),
            .idx  (idx_s)
        );

        // Read mux: zero while clearing or for r0, then bypass, then array.
        always_comb begin
            d_s = {DATA_W{1'b0}};
            if (state_r == CLEAR) begin
                d_s = {DATA_W{1'b0}};
            end else if ((ZERO_R0 != 0) && (a_s == {ADDR_W{1'b0}})) begin
                d_s = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && hit_s) begin
                d_s = wd_s[idx_s];
            end else begin
                d_s = mem_s[a_s];
            end
        end

        assign rd[p*DATA_W +: DATA_W] = d_s;
    end

    assign ready    = ready_r;
    assign conflict = conflict_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on / off, 4R2W) share stimulus;
// directed vector table plus random traffic against an array model.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   we  = 2'b00;
    logic [9:0]   wa  = 10'd0;
    logic [63:0]  wd  = 64'd0;
    logic [19:0]  ra  = 20'd0;
    logic [127:0] rd_b, rd_n;
    logic         ready_b, ready_n, conf_b, conf_n;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2), .ZERO_R0(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_b), .ready(ready_b), .conflict(conf_b));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .NUM_WR(2), .ZERO_R0(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra),
        .rd(rd_n), .ready(ready_n), .conflict(conf_n));

    int          n_pass = 0;
    int          n_tot  = 0;
    logic [31:0] mem_m [32];
    bit          run_m  = 1'b0;
    logic        conf_m = 1'b0;

    typedef struct packed {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  rax;
        logic [31:0] eb0;
        logic [31:0] ebx;
        logic [31:0] en0;
        logic [31:0] enx;
        logic        conf;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] port_rd(input logic [127:0] v, input int p);
        return v[p*32 +: 32];
    endfunction

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp && run_m) begin
            if (we[1] && wa[9:5] == a) return wd[63:32];
            if (we[0] && wa[4:0] == a) return wd[31:0];
        end
        return mem_m[a];
    endfunction

    // Commit the current inputs to the model, then advance one clock.
    task automatic tick();
        logic nx;
        nx = run_m && (we == 2'b11) && (wa[4:0] == wa[9:5]) && (wa[4:0] != 5'd0);
        if (run_m) begin
            for (int k = 0; k < 2; k++)
                if (we[k] && wa[k*5 +: 5] != 5'd0) mem_m[wa[k*5 +: 5]] = wd[k*32 +: 32];
        end
        @(posedge clk);
        #1;
        conf_m = nx;
    endtask

    task automatic wait_sweep(input string nm);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (ready_b) break;
            if (i < 4) chk({nm, "_rd_clear"}, port_rd(rd_b, 0), 32'd0);
        end
        chk({nm, "_sweep_len"}, 32'(n), 32'd32);
        chk({nm, "_ready_n"}, {31'd0, ready_n}, 32'd1);
    endtask

    task automatic read_all(input string nm);
        we = 2'b00;
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 4; p++) ra[p*5 +: 5] = 5'(i*4 + p);
            #2;
            for (int p = 0; p < 4; p++) begin
                chk({nm, "_b"}, port_rd(rd_b, p), 32'd0);
                chk({nm, "_n"}, port_rd(rd_n, p), 32'd0);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        vecs[0]  = '{2'b01, 5'd7, 5'd0, 32'hDEADBEEF, 32'd0, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0};
        vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{2'b01, 5'd9, 5'd0, 32'h12345678, 32'd0, 5'd9, 5'd7, 32'h12345678, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd7, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{2'b11, 5'd3, 5'd3, 32'h1111, 32'h2222, 5'd3, 5'd7, 32'h2222, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3, 32'h2222, 32'h2222, 32'h2222, 32'h2222, 1'b1};
        vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd3, 32'h2222, 32'h2222, 32'h2222, 32'h2222, 1'b0};
        vecs[7]  = '{2'b11, 5'd0, 5'd0, 32'h1111, 32'h2222, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
        vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0};
        vecs[9]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd3, 32'd0, 32'h2222, 32'd0, 32'h2222, 1'b0};
        vecs[10] = '{2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd3, 32'd0, 32'h2222, 32'd0, 32'h2222, 1'b0};

        // Reset with a write attempted throughout the sweep.
        #1 rst = 1'b0;
        we = 2'b01; wa = {5'd0, 5'd5}; wd = {32'd0, 32'hAAAA5555}; ra = {4{5'd5}};
        #2;
        chk("rst_ready", {31'd0, ready_b}, 32'd0);
        chk("rst_conflict", {31'd0, conf_b}, 32'd0);
        chk("rst_rd", port_rd(rd_b, 0), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        wait_sweep("sweep1");
        run_m = 1'b1;
        conf_m = 1'b0;
        read_all("clear1");

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            we = vecs[i].we;
            wa = {vecs[i].wa1, vecs[i].wa0};
            wd = {vecs[i].wd1, vecs[i].wd0};
            ra = {vecs[i].rax, vecs[i].rax, vecs[i].rax, vecs[i].ra0};
            #2;
            chk($sformatf("vec%0d_b0", i), port_rd(rd_b, 0), vecs[i].eb0);
            chk($sformatf("vec%0d_n0", i), port_rd(rd_n, 0), vecs[i].en0);
            for (int p = 1; p < 4; p++) begin
                chk($sformatf("vec%0d_b%0d", i, p), port_rd(rd_b, p), vecs[i].ebx);
                chk($sformatf("vec%0d_n%0d", i, p), port_rd(rd_n, p), vecs[i].enx);
            end
            chk($sformatf("vec%0d_conf", i), {31'd0, conf_b}, {31'd0, vecs[i].conf});
            tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            we = 2'($urandom_range(0, 3));
            wa[4:0] = 5'($urandom_range(0, 31));
            wa[9:5] = ($urandom_range(0, 3) == 0) ? wa[4:0] : 5'($urandom_range(0, 31));
            wd = {$urandom, $urandom};
            for (int p = 0; p < 4; p++)
                ra[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wa[($urandom_range(0, 1))*5 +: 5]
                                                             : 5'($urandom_range(0, 31));
            #2;
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("rnd%0d_b%0d", c, p), port_rd(rd_b, p), exp_rd(1'b1, ra[p*5 +: 5]));
                chk($sformatf("rnd%0d_n%0d", c, p), port_rd(rd_n, p), exp_rd(1'b0, ra[p*5 +: 5]));
            end
            chk($sformatf("rnd%0d_conf_b", c), {31'd0, conf_b}, {31'd0, conf_m});
            chk($sformatf("rnd%0d_conf_n", c), {31'd0, conf_n}, {31'd0, conf_m});
            tick();
        end

        // Fill r1..r31 with their index, then reset mid-cycle.
        for (int i = 1; i < 32; i++) begin
            we = 2'b01; wa = {5'd0, 5'(i)}; wd = {32'd0, 32'(i)}; ra = {4{5'(i)}};
            tick();
        end
        we = 2'b00; ra = {5'd31, 5'd20, 5'd1, 5'd7};
        #2;
        chk("fill_r7", port_rd(rd_n, 0), 32'd7);
        chk("fill_r31", port_rd(rd_n, 3), 32'd31);
        #2 rst = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, ready_b}, 32'd0);
        chk("midrst_rd", port_rd(rd_b, 0), 32'd0);
        run_m = 1'b0;
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
        #9 rst = 1'b1;
        wait_sweep("sweep2");
        run_m = 1'b1;
        conf_m = 1'b0;
        chk("sweep2_conf", {31'd0, conf_b}, 32'd0);
        read_all("clear2");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
